// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding, default sizes
// and the requester-index width helper.
package adder_arb_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Width of a requester index; never below one bit so ports stay legal.
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request found
// searching upward from i_ptr with wrap-around.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any_grant
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    // Walk from the farthest offset back to the pointer so the nearest hit is written last and wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      automatic int idx = (int'(i_ptr) + off) % NUM_REQ;
      if (i_req[ID_W'(idx)]) begin
        o_grant              = '0;
        o_grant[ID_W'(idx)]  = 1'b1;
        o_grant_idx          = ID_W'(idx);
        o_any_grant          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Sequencer sharing one combinational adder among NUM_REQ requesters:
// accept in IDLE, drive the adder in ISSUE, hold the result in RESP.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] i_req_b,
  output logic [WIDTH-1:0]              o_add_a,
  output logic [WIDTH-1:0]              o_add_b,
  input  logic [WIDTH:0]                i_add_sum,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [WIDTH:0]                o_rsp_sum,
  output logic [ID_W-1:0]               o_rsp_id
);

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [WIDTH-1:0]    r_op_a;
  logic [WIDTH-1:0]    r_op_b;
  logic [WIDTH:0]      r_sum;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_any_grant;
  logic                w_accept;
  logic [ID_W-1:0]     w_ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  assign w_ptr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    o_req_ready  = '0;
    o_add_a      = '0;
    o_add_b      = '0;
    o_rsp_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Ready is held low while reset is asserted so nothing looks accepted.
        if (!rst && w_any_grant) begin
          o_req_ready  = w_grant;
          w_accept     = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        o_add_a      = r_op_a;
        o_add_b      = r_op_b;
        w_next_state = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_sum  <= '0;
    end else begin
      if (w_accept) begin
        r_op_a <= i_req_a[w_grant_idx];
        r_op_b <= i_req_b[w_grant_idx];
        r_id   <= w_grant_idx;
      end
      if (r_state == ISSUE) r_sum <= i_add_sum;
      // Priority rotates to the requester after the one just served.
      if (r_state == RESP && i_rsp_ready) r_ptr <= w_ptr_next;
    end
  end

  assign o_rsp_sum = r_sum;
  assign o_rsp_id  = r_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a transaction-level model predicts grants,
// handshake timing and sums; a separate monitor checks each delivered response.
module tb_adder_arbiter;

  localparam int N = 2;
  localparam int W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][W-1:0] req_a;
  logic [N-1:0][W-1:0] req_b;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W:0]        add_sum;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_sum;
  logic [0:0]        rsp_id;

  always #5 clk = ~clk;

  // The shared adder the arbiter fronts.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .i_add_sum   (add_sum),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_id    (rsp_id)
  );

  typedef struct packed {
    logic [0:0] id;
    logic [W:0] sum;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: busy phases of the single shared adder.
  bit         m_known = 1'b0;
  bit         m_issue = 1'b0;
  bit         m_resp  = 1'b0;
  int         m_ptr   = 0;
  int         m_id    = 0;
  logic [W-1:0] m_op_a = '0;
  logic [W-1:0] m_op_b = '0;
  int         tick_no = 0;
  logic [N-1:0] last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT combinational/registered outputs with the model at the
  // negedge, advance the model across the coming edge, return predicted acceptances.
  task automatic tick(output logic [N-1:0] acc);
    int w;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    w = -1;
    if (!rst && !m_issue && !m_resp) begin
      for (int off = 0; off < N; off++) begin
        int idx = (m_ptr + off) % N;
        if (w < 0 && req_valid[idx[0]]) w = idx;
      end
    end
    exp_ready  = (w >= 0) ? (N'(1) << w) : '0;
    last_ready = req_ready;
    if (m_known) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      check("add_a", 32'(add_a), m_issue ? 32'(m_op_a) : 32'd0);
      check("add_b", 32'(add_b), m_issue ? 32'(m_op_b) : 32'd0);
    end
    acc = exp_ready;
    if (rst) begin
      m_known = 1'b1;
      m_issue = 1'b0;
      m_resp  = 1'b0;
      m_ptr   = 0;
      m_id    = 0;
      exp_q.delete();
    end else if (w >= 0) begin
      m_op_a = req_a[w[0]];
      m_op_b = req_b[w[0]];
      m_id   = w;
      m_issue = 1'b1;
      exp_q.push_back('{id: w[0], sum: ({1'b0, m_op_a} + {1'b0, m_op_b})});
    end else if (m_issue) begin
      m_issue = 1'b0;
      m_resp  = 1'b1;
    end else if (m_resp && rsp_ready) begin
      m_resp = 1'b0;
      m_ptr  = (m_id + 1) % N;
    end
    @(posedge clk);
    #1;
    tick_no++;
  endtask

  task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N-1:0] acc;
    acc = '0;
    req_a[idx[0]] = a;
    req_b[idx[0]] = b;
    req_valid = req_valid | (N'(1) << idx);
    for (int k = 0; k < 20; k++) begin
      tick(acc);
      if (acc[idx[0]]) break;
    end
    if (!acc[idx[0]]) check("send_timeout", 32'(acc[idx[0]]), 32'd1);
    req_valid = req_valid & ~(N'(1) << idx);
  endtask

  task automatic wait_free();
    logic [N-1:0] acc;
    for (int k = 0; k < 20; k++) begin
      if (!m_issue && !m_resp) break;
      tick(acc);
    end
    check("drain_idle", 32'(rsp_valid), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks that a
  // stalled response does not change.
  logic       held = 1'b0;
  logic [W:0] h_sum;
  logic [0:0] h_id;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst && m_known && rsp_valid === 1'b1) begin
      if (held) begin
        check("hold_sum", 32'(rsp_sum), 32'(h_sum));
        check("hold_id", 32'(rsp_id), 32'(h_id));
      end
      if (rsp_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
          check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        end
      end else begin
        held  = 1'b1;
        h_sum = rsp_sum;
        h_id  = rsp_id;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    logic [N-1:0] acc;
    int acc_tick[$];
    int acc_id[$];

    rst       = 1'b1;
    req_valid = N'($urandom);
    req_a     = (N*W)'($urandom);
    req_b     = (N*W)'($urandom);
    rsp_ready = 1'b0;
    tick(acc);
    tick(acc);
    rst       = 1'b0;
    req_valid = '0;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_add_a", 32'(add_a), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    // Single request, then carry-out cases.
    rsp_ready = 1'b1;
    send(0, 4'b1010, 4'b0101);
    tick(acc);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_sum", 32'(rsp_sum), 32'b01111);
    check("single_id", 32'(rsp_id), 32'd0);
    tick(acc);
    send(1, 4'b1001, 4'b1001);
    tick(acc);
    check("carry_sum", 32'(rsp_sum), 32'b10010);
    check("carry_id", 32'(rsp_id), 32'd1);
    tick(acc);
    send(1, 4'b1111, 4'b1111);
    tick(acc);
    check("carry_max_sum", 32'(rsp_sum), 32'b11110);
    check("carry_max_id", 32'(rsp_id), 32'd1);
    tick(acc);

    // Round robin with both requesters continuously valid.
    req_a     = (N*W)'($urandom);
    req_b     = (N*W)'($urandom);
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick(acc);
      if (last_ready != '0) begin
        acc_tick.push_back(tick_no);
        acc_id.push_back(last_ready[1] ? 1 : 0);
      end
      if (acc != '0) begin
        req_a[acc[1]] = W'($urandom);
        req_b[acc[1]] = W'($urandom);
      end
    end
    req_valid = '0;
    check("rr_count", 32'(acc_id.size()), 32'd4);
    for (int i = 0; i < acc_id.size(); i++) begin
      check("rr_id", 32'(acc_id[i]), 32'(i % 2));
      if (i > 0) check("rr_spacing", 32'(acc_tick[i] - acc_tick[i-1]), 32'd3);
    end
    wait_free();

    // Backpressure: response stalled five cycles with both requesters pending.
    rsp_ready = 1'b0;
    send(0, W'($urandom), W'($urandom));
    req_a[1]  = W'($urandom);
    req_b[1]  = W'($urandom);
    req_valid = 2'b11;
    tick(acc);
    repeat (5) tick(acc);
    check("bp_still_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick(acc);
    tick(acc);
    check("bp_next_grant", 32'(last_ready), 32'b10);
    req_valid = '0;
    wait_free();

    // Reset while requester 1's result waits in RESP.
    rsp_ready = 1'b0;
    send(1, W'($urandom), W'($urandom));
    tick(acc);
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 2'b11;
    tick(acc);
    check("rst_next_grant", 32'(last_ready), 32'b01);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_free();

    // Randomized traffic with optional request withdrawal and random backpressure.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i[0]] && $urandom_range(0, 2) == 0) begin
          req_a[i[0]]     = W'($urandom);
          req_b[i[0]]     = W'($urandom);
          req_valid[i[0]] = 1'b1;
        end else if (req_valid[i[0]] && $urandom_range(0, 15) == 0) begin
          req_valid[i[0]] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      req_valid = req_valid & ~acc;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_free();
    tick(acc);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares a single combinational 4-bit adder among several requesters. Each requester presents an operand pair with a valid/ready handshake; the arbiter grants one, drives the shared adder with registered operands, captures the widened sum, and returns it with the requester ID over a response handshake. It sits between the stimulus sources and the adder, replacing direct multi-driver access to the adder inputs.

## Interface

- NUM_REQ, 2, number of requesters (legal range 2..8)
- WIDTH, 4, operand width; the sum is WIDTH+1 bits
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  input  NUM_REQ x WIDTH  per-requester operand A
- req_b  input  NUM_REQ x WIDTH  per-requester operand B
- add_a  output  WIDTH  operand A to the shared adder
- add_b  output  WIDTH  operand B to the shared adder
- add_sum  input  WIDTH+1  sum from the shared adder (combinational)
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result consumer ready
- rsp_sum  output  WIDTH+1  captured sum
- rsp_id  output  ID_W = $clog2(NUM_REQ)  index of the served requester

## Operation

- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is high, rr_arbiter picks the first valid index, searching upward from ptr with wrap-around.
  - req_ready[grant] = 1 combinationally (only in IDLE, only for the grant).
  - Handshake completes the same cycle: latch req_a/req_b into op_a/op_b, store grant into id_q, go to ISSUE.
  - If no request is valid, stay in IDLE; all req_ready are 0.
- ISSUE:
  - add_a/add_b present op_a/op_b.
  - At the clock edge, capture add_sum into sum_q, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_sum = sum_q; rsp_id = id_q.
  - Hold all response outputs stable while rsp_ready = 0.
  - When rsp_valid && rsp_ready: go to IDLE and set ptr = (id_q + 1) mod NUM_REQ.
- Arithmetic:
  - The full WIDTH+1 carry is preserved; no truncation or saturation.
  - The arbiter performs no arithmetic on the sum; it passes add_sum through unchanged.
- Fairness: a continuously valid requester is served at most NUM_REQ−1 grants after any other grant.
- Requester-side rules:
  - A requester must hold valid, a and b stable until it sees ready.
  - A request dropped before it is granted is ignored without error.

## Timing

- Reset (synchronous, rst high at the edge):
  - state = IDLE, ptr = 0.
  - op_a = op_b = 0, sum_q = 0, id_q = 0.
  - rsp_valid = 0, req_ready = 0.
  - add_a = add_b = 0.
- Reset mid-operation, in any state, aborts the transaction: the in-flight result is discarded and rsp_valid is 0 in the cycle after the reset edge.
- Latency:
  - Request accepted at edge N.
  - Adder driven during cycle N+1.
  - rsp_valid high from edge N+2.
- Peak throughput: one transaction per 3 cycles when rsp_ready is held high.
- No request is accepted while in ISSUE or RESP; all req_ready are 0 there.
- Simultaneous events:
  - Multiple valid requests: the ptr-ordered winner is served; losers wait.
  - A response completes in the same cycle a new request becomes valid: the new request is accepted one cycle later, in IDLE.
- ptr wraps from NUM_REQ−1 to 0.

## Structure

- Shared package adder_arb_pkg:
  - state_t enum {IDLE, ISSUE, RESP}.
  - Default parameters for WIDTH and NUM_REQ.
  - An id_w function returning $clog2(NUM_REQ).
- Sub-module rr_arbiter:
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; reusable by other shared-resource controllers.
- Top level: FSM, operand/result registers, pointer update, adder port muxing.

## Test plan

- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, req_ready = 0, state IDLE.
- Single request: req0 a=1010, b=0101 -> req_ready[0] high one cycle; rsp_valid 2 cycles later with rsp_sum = 01111, rsp_id = 0.
- Carry: req1 a=1001, b=1001 -> rsp_sum = 10010, rsp_id = 1; a=1111, b=1111 -> 11110.
- Round robin: both requesters valid continuously, rsp_ready = 1 -> rsp_id sequence 0,1,0,1; one transaction every 3 cycles.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_sum and rsp_id stable; req_ready stays 0 despite pending valids; completes on the first cycle rsp_ready is high.
- Reset mid-RESP with req1 result pending -> rsp_valid 0 next cycle; with both requesters then valid, the next grant is requester 0.
